// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: issues one request at a time, holds
// the returned word for execute, and follows sequential or redirected flow.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          EXC_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic        inst_ack,
  input  logic        pc_Sel,
  input  logic [31:0] br_target,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [2:0] BOOT = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  logic [2:0]      state, state_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] pc_d, inst_d, imem_addr_d;
  logic            misalign_err_d;

  // State and all output registers; reset also drops any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      pc           <= RESET_PC;
      inst         <= NOP_INST;
      inst_valid   <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      fetch_pc     <= fetch_pc_d;
      pc           <= pc_d;
      inst         <= inst_d;
      inst_valid   <= (state_d == HOLD);
      imem_req     <= (state_d == REQ);
      imem_addr    <= imem_addr_d;
      misalign_err <= misalign_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state;
    fetch_pc_d     = fetch_pc;
    pc_d           = pc;
    inst_d         = inst;
    misalign_err_d = misalign_err;

    case (state)
      BOOT: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          pc_d    = fetch_pc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (inst_ack) begin
          if (!pc_Sel) begin
            fetch_pc_d = pc + XLEN'(4);
            state_d    = REQ;
          end else if (br_target[1:0] == 2'b00) begin
            fetch_pc_d = br_target;
            state_d    = REQ;
          end else begin
            misalign_err_d = 1'b1;
            if (EXC_HALT) begin
              state_d = HALT;
            end else begin
              fetch_pc_d = {br_target[31:2], 2'b00};
              state_d    = REQ;
            end
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    // Address register only loads when a request is about to be issued.
    imem_addr_d = (state_d == REQ) ? fetch_pc_d : imem_addr;
  end

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a transaction-level model tracks the expected
// fetch address and held word while a responder answers with random latency.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        inst_ack;
  logic        pc_Sel;
  logic [31:0] br_target;
  logic        misalign_err;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .EXC_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .inst_ack(inst_ack), .pc_Sel(pc_Sel), .br_target(br_target),
    .misalign_err(misalign_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] cur_word;
  bit          halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst",  inst, 32'h0000_0013);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_err",   32'(misalign_err), 32'd0);
  endtask

  // Called at the negedge of the cycle that should carry the request.
  task automatic fetch(input int k, input bit spurious, input logic [31:0] w);
    chk("req_pulse", 32'(imem_req), 32'd1);
    chk("req_addr",  imem_addr, exp_pc);
    chk("req_valid", 32'(inst_valid), 32'd0);
    imem_rvalid = spurious;
    imem_rdata  = $urandom;
    for (int j = 1; j <= k; j++) begin
      step();
      chk("wait_req",   32'(imem_req), 32'd0);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      imem_rvalid = (j == k);
      imem_rdata  = (j == k) ? w : $urandom;
      inst_ack    = 1'($urandom_range(0, 1));
      pc_Sel      = 1'($urandom_range(0, 1));
      br_target   = $urandom;
    end
    step();
    imem_rvalid = 1'b0;
    inst_ack    = 1'b0;
    pc_Sel      = 1'b0;
    chk("resp_valid", 32'(inst_valid), 32'd1);
    chk("resp_inst",  inst, w);
    chk("resp_pc",    pc, exp_pc);
    chk("opcode",     32'(opcode), 32'(w[6:0]));
    chk("funct3",     32'(funct3), 32'(w[14:12]));
    chk("funct7",     32'(funct7), 32'(w[31:25]));
    cur_word = w;
  endtask

  // Holds for h cycles (with spurious responses), then acks with the given redirect.
  task automatic hold_and_ack(input int h, input bit sel, input logic [31:0] tgt);
    for (int j = 0; j < h; j++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hFFFF_FFFF;
      pc_Sel      = 1'($urandom_range(0, 1));
      step();
      chk("hold_inst",  inst, cur_word);
      chk("hold_pc",    pc, exp_pc);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_req",   32'(imem_req), 32'd0);
    end
    imem_rvalid = 1'b0;
    inst_ack    = 1'b1;
    pc_Sel      = sel;
    br_target   = tgt;
    step();
    inst_ack = 1'b0;
    pc_Sel   = 1'b0;
    if (!sel)                exp_pc = exp_pc + 32'd4;
    else if (tgt[1:0] == 0)  exp_pc = tgt;
    else                     halted = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_state();
    rst_n  = 1'b1;
    halted = 1'b0;
    exp_pc = 32'h0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ack = 1'b0; pc_Sel = 1'b0; br_target = 32'h0;
    halted = 1'b0; exp_pc = 32'h0; cur_word = 32'h0;
    step();
    do_reset();

    // First fetch after reset, fixed word and latency 2.
    fetch(2, 1'b0, 32'h0050_0093);
    chk("first_opcode", 32'(opcode), 32'h13);
    chk("first_funct3", 32'(funct3), 32'h0);

    hold_and_ack(1, 1'b1, 32'h0000_0010);
    fetch(1, 1'b1, $urandom);
    hold_and_ack(0, 1'b0, 32'h0);
    chk("seq_0x14", imem_addr, 32'h0000_0014);
    fetch(3, 1'b0, $urandom);

    hold_and_ack(2, 1'b1, 32'hFFFF_FFFC);
    fetch(1, 1'b0, $urandom);
    hold_and_ack(2, 1'b0, 32'h0);
    chk("wrap_zero", imem_addr, 32'h0);
    fetch(2, 1'b1, $urandom);

    hold_and_ack(0, 1'b1, 32'h0000_0100);
    fetch(4, 1'b0, $urandom);
    chk("branch_pc", pc, 32'h0000_0100);

    for (int t = 0; t < 40; t++) begin
      hold_and_ack($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      fetch($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset while a request is outstanding; the late response must be dropped.
    hold_and_ack(0, 1'b0, 32'h0);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    chk_reset_state();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk("late_valid", 32'(inst_valid), 32'd0);
    chk("late_inst",  inst, 32'h0000_0013);
    exp_pc = 32'h0;
    fetch(2, 1'b1, $urandom);

    // Misaligned redirect halts fetch.
    hold_and_ack(1, 1'b1, 32'h0000_0102);
    chk("halt_flag", 32'(halted), 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk("halt_err",   32'(misalign_err), 32'd1);
      chk("halt_valid", 32'(inst_valid), 32'd0);
      chk("halt_req",   32'(imem_req), 32'd0);
      imem_rvalid = 1'($urandom_range(0, 1));
      inst_ack    = 1'($urandom_range(0, 1));
      pc_Sel      = 1'b1;
      br_target   = 32'h0000_0200;
      step();
    end
    imem_rvalid = 1'b0; inst_ack = 1'b0; pc_Sel = 1'b0;

    // Reset recovers from halt and clears the sticky flag.
    do_reset();
    chk("recover_err", 32'(misalign_err), 32'd0);
    fetch(1, 1'b0, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter EXC_HALT, default 1, meaning a misaligned redirect target halts fetch.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port imem_req  output  1  one-cycle fetch request pulse.
REQ-006 The block SHALL have port imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-007 The block SHALL have port imem_rvalid  input  1  instruction-memory response strobe.
REQ-008 The block SHALL have port imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-009 The block SHALL have port inst_valid  output  1  inst/pc/decode fields are valid.
REQ-010 The block SHALL have port inst  output  32  held instruction word.
REQ-011 The block SHALL have port pc  output  32  address of the held instruction.
REQ-012 The block SHALL have port opcode  output  7  inst[6:0], the decode field fed to the control unit.
REQ-013 The block SHALL have port funct3  output  3  inst[14:12], the decode field fed to the control unit.
REQ-014 The block SHALL have port funct7  output  7  inst[31:25], the decode field fed to the control unit.
REQ-015 The block SHALL have port inst_ack  input  1  execute has committed the held instruction this cycle.
REQ-016 The block SHALL have port pc_Sel  input  1  redirect request, sampled only with inst_ack.
REQ-017 The block SHALL have port br_target  input  32  redirect target for jal/jalr/taken branch.
REQ-018 The block SHALL have port misalign_err  output  1  sticky flag: redirect target[1:0]!=0.

Function
REQ-019 The FSM SHALL have exactly the states BOOT, REQ, WAIT, HOLD and HALT.
REQ-020 In BOOT the block SHALL spend one cycle, issue nothing and go to REQ.
REQ-021 In REQ the block SHALL drive imem_req=1 and imem_addr=fetch_pc for exactly one cycle, then go to WAIT.
REQ-022 In WAIT, on imem_rvalid=1 the block SHALL register imem_rdata into inst, fetch_pc into pc, and go to HOLD.
REQ-023 In HOLD the block SHALL drive inst_valid=1 and keep inst/pc stable until inst_ack=1.
REQ-024 On inst_ack with pc_Sel=0 the block SHALL set fetch_pc=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and go to REQ.
REQ-025 On inst_ack with pc_Sel=1 and br_target[1:0]=0 the block SHALL set fetch_pc=br_target and go to REQ.
REQ-026 On inst_ack with pc_Sel=1 and br_target[1:0]!=0 the block SHALL set misalign_err=1 and go to HALT when EXC_HALT=1, else force fetch_pc={br_target[31:2],2'b00} and go to REQ.
REQ-027 In HALT the block SHALL drive inst_valid=0 and imem_req=0 and stay until reset.
REQ-028 The block SHALL ignore imem_rvalid in BOOT, REQ, HOLD and HALT; a response is accepted only in WAIT.
REQ-029 The block SHALL ignore inst_ack and pc_Sel whenever inst_valid=0.
REQ-030 The fetch latency SHALL be: imem_req in cycle n, rvalid in cycle n+k (k>=1), inst_valid from cycle n+k+1, next imem_req in cycle a+1 where a is the ack cycle.
REQ-031 opcode, funct3 and funct7 SHALL be pure slices of the registered inst, with no extra cycle of latency.
REQ-032 At most one request SHALL be outstanding at any time.

Reset
REQ-033 With rst_n=0 at a clock edge, the block SHALL enter BOOT and set fetch_pc=RESET_PC, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, imem_req=0, imem_addr=RESET_PC and misalign_err=0.
REQ-034 Reset SHALL take effect from any state, including WAIT with a request outstanding; a response to that request arriving after reset falls in BOOT or REQ and is discarded.

Verification
REQ-035 Reset release with RESET_PC=0: imem_req=1 with addr 0x0 in the second cycle after rst_n rises; rdata 0x00500093 with k=2 gives inst_valid=1, pc=0, opcode=7'h13, funct3=0.
REQ-036 Sequential ack with pc_Sel=0 at pc=0x10 gives next imem_addr=0x14; at pc=0xFFFFFFFC it gives next imem_addr=0x0.
REQ-037 Ack with pc_Sel=1 and br_target=0x100 gives next imem_addr=0x100 and pc=0x100 after the response.
REQ-038 Ack with pc_Sel=1 and br_target=0x102, EXC_HALT=1: misalign_err=1, inst_valid=0 and no further imem_req.
REQ-039 Spurious imem_rvalid in HOLD with rdata 0xFFFFFFFF leaves inst unchanged; rst_n=0 during WAIT followed by a late rvalid gives no inst_valid until a fresh fetch of RESET_PC completes.
